// File: rtl/csa_resolve_seq_if.sv
// Operand and result handshakes of the CSA carry-propagate resolver.
// The producer/consumer side uses master; the resolver uses slave.
interface csa_resolve_seq_if #(
    parameter int unsigned W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s_in;
    logic [W-1:0] c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum_out;

    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out
    );

    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, sum_out
    );
endinterface

// File: rtl/csa_resolve_seq.sv
// Sequential resolver of a CSA sum/carry pair, SEG bits per cycle with a registered carry.
// Optional CSA_RESOLVE_CHK_EN adds chk_err, flagging a set c_in LSB on acceptance.
module csa_resolve_seq #(
    parameter int unsigned W   = 12,
    parameter int unsigned SEG = 4
) (
    input logic             clk,
    input logic             rst,
    csa_resolve_seq_if.slave bus
`ifdef CSA_RESOLVE_CHK_EN
    ,
    output logic            chk_err
`endif
);
    localparam int unsigned   NSEG    = (W + SEG - 1) / SEG;
    localparam int unsigned   CW      = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CW-1:0] LastSeg = CW'(NSEG - 1);
    localparam logic [W:0]    SegMask = (W + 1)'({(SEG + 1){1'b1}});

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  s_q, s_d, c_q, c_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] seg_q, seg_d;
    logic [W:0]    sum_q, sum_d;

    logic [31:0]   base;
    logic [W-1:0]  s_sh, c_sh;
    logic [SEG:0]  seg_sum;
    logic          accept;

    // Shifting right zero-fills, so a short last segment sees zero upper lanes.
    always_comb begin
        base    = 32'(seg_q) * SEG;
        s_sh    = s_q >> base;
        c_sh    = c_q >> base;
        seg_sum = {1'b0, s_sh[SEG-1:0]} + {1'b0, c_sh[SEG-1:0]} + (SEG + 1)'(carry_q);
    end

    assign accept = (state_q == StIdle) && bus.in_valid;

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        c_d           = c_q;
        carry_d       = carry_q;
        seg_d         = seg_q;
        sum_d         = sum_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    s_d     = bus.s_in;
                    c_d     = bus.c_in;
                    carry_d = 1'b0;
                    seg_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // Segment carry lands one lane above; the next segment overwrites it,
                // and on the last segment it becomes the final carry (or falls off).
                sum_d   = (sum_q & ~(SegMask << base)) | ((W + 1)'(seg_sum) << base);
                carry_d = seg_sum[SEG];
                seg_d   = seg_q + CW'(1);
                if (seg_q == LastSeg) begin
                    seg_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.sum_out = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            seg_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            seg_q   <= seg_d;
            sum_q   <= sum_d;
        end
    end

`ifdef CSA_RESOLVE_CHK_EN
    logic chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (accept) begin
            chk_d = bus.c_in[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;
`else
    // No convention check: c_in[0] is added like any other bit.
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule
